// File: rtl/mask_op_arbiter_if.sv
// rtl/mask_op_arbiter_if.sv - request/result bundle between requesters and the mask-op arbiter
interface mask_op_arbiter_if #(
    parameter int W    = 4,
    parameter int NREQ = 3
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   order;
    logic [NREQ-1:0]   bnarrow;
    logic [NREQ*W-1:0] opa;
    logic [NREQ*W-1:0] opb;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              res_valid;
    logic [1:0]        res_id;
    logic [W-1:0]      res;
    logic              res_ready;

    modport master (
        output req, order, bnarrow, opa, opb, res_ready,
        input  gnt, busy, res_valid, res_id, res
    );

    modport slave (
        input  req, order, bnarrow, opa, opb, res_ready,
        output gnt, busy, res_valid, res_id, res
    );
endinterface

// File: rtl/mask_op_arbiter.sv
// rtl/mask_op_arbiter.sv - round-robin arbiter issuing one lane-order-aware AND per grant
module mask_op_arbiter #(
    parameter int W    = 4,
    parameter int NREQ = 3
) (
    input logic              clk,
    input logic              rst,
    mask_op_arbiter_if.slave bus
);
    localparam int IW = 2;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   sel;
    logic            sel_ok;
    logic            cap_order;
    logic            cap_bn;
    logic [W-1:0]    cap_a;
    logic [W-1:0]    cap_b;
    logic [IW-1:0]   cap_id;
    logic [W-1:0]    a_n;
    logic [W-1:0]    b_n;
    logic [W-1:0]    r_n;
    logic [W-1:0]    res_next;
    logic [NREQ-1:0] gnt_q;
    logic            busy_q;
    logic            valid_q;
    logic [IW-1:0]   id_q;
    logic [W-1:0]    res_q;

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.res_valid = valid_q;
    assign bus.res_id    = id_q;
    assign bus.res       = res_q;

    function automatic logic [W-1:0] bit_rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int j = 0; j < W; j++) begin
            r[j] = v[W-1-j];
        end
        return r;
    endfunction

    // Round-robin search starting at ptr; first pending request wins.
    always_comb begin
        sel    = '0;
        sel_ok = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            if (!sel_ok && bus.req[(int'(ptr) + off) % NREQ]) begin
                sel    = IW'((int'(ptr) + off) % NREQ);
                sel_ok = 1'b1;
            end
        end
    end

    // The AND is done in the numeric (descending) domain, then mapped back to lane order.
    always_comb begin
        a_n = cap_order ? bit_rev(cap_a) : cap_a;
        b_n = cap_order ? bit_rev(cap_b) : cap_b;
        if (cap_bn) begin
            b_n[W-1:2] = '0;
        end
        r_n      = a_n & b_n;
        res_next = cap_order ? bit_rev(r_n) : r_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            res_q     <= '0;
            cap_order <= 1'b0;
            cap_bn    <= 1'b0;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_ok) begin
                        cap_order <= bus.order[sel];
                        cap_bn    <= bus.bnarrow[sel];
                        cap_a     <= bus.opa[int'(sel)*W +: W];
                        cap_b     <= bus.opb[int'(sel)*W +: W];
                        cap_id    <= sel;
                        gnt_q     <= NREQ'(1) << sel;
                        busy_q    <= 1'b1;
                        ptr       <= IW'((int'(sel) + 1) % NREQ);
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    gnt_q   <= '0;
                    res_q   <= res_next;
                    id_q    <= cap_id;
                    valid_q <= 1'b1;
                    state   <= RESP;
                end
                RESP: begin
                    if (bus.res_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mask_op_arbiter.sv
// tb/tb_mask_op_arbiter.sv - directed and random scoreboard bench for mask_op_arbiter
module tb_mask_op_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   mptr;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] res;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    mask_op_arbiter_if #(.W(4), .NREQ(3)) bus ();

    mask_op_arbiter #(.W(4), .NREQ(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Lane bit p maps to numeric bit n; bnarrow keeps only numeric bits 0 and 1 of B.
    function automatic logic [3:0] model_res(input logic o, input logic bn,
                                             input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        int p;
        r = '0;
        for (int n = 0; n < 4; n++) begin
            p    = o ? 3 - n : n;
            r[p] = a[p] & b[p] & (!bn || n < 2);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mptr = 0;
        exp_q.delete();
        chk("rst_gnt", 16'(bus.gnt), 16'h0);
        chk("rst_busy", 16'(bus.busy), 16'h0);
        chk("rst_valid", 16'(bus.res_valid), 16'h0);
        chk("rst_id", 16'(bus.res_id), 16'h0);
        chk("rst_res", 16'(bus.res), 16'h0);
    endtask

    task automatic start(input logic [2:0] r, input logic [2:0] o, input logic [2:0] bn,
                         input logic [11:0] a, input logic [11:0] b);
        int k;
        exp_t e;
        bus.req = r; bus.order = o; bus.bnarrow = bn; bus.opa = a; bus.opb = b;
        bus.res_ready = 1'b0;
        k = -1;
        for (int off = 0; off < 3; off++) begin
            if (k < 0 && r[(mptr + off) % 3]) k = (mptr + off) % 3;
        end
        e.id  = 2'(k);
        e.res = model_res(o[k], bn[k], a[k*4 +: 4], b[k*4 +: 4]);
        exp_q.push_back(e);
        mptr = (k + 1) % 3;
        step();
        chk("gnt", 16'(bus.gnt), 16'(3'b001 << k));
        chk("exec_busy", 16'(bus.busy), 16'h1);
        chk("exec_valid", 16'(bus.res_valid), 16'h0);
        // Disturb operands in flight; the captured lane must win.
        bus.opa = 12'($urandom); bus.opb = 12'($urandom);
        bus.order = 3'($urandom); bus.bnarrow = 3'($urandom);
    endtask

    task automatic finish(input int hold);
        step();
        chk("resp_valid", 16'(bus.res_valid), 16'h1);
        chk("resp_gnt", 16'(bus.gnt), 16'h0);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 16'h1, 16'h0);
            cur = '0;
        end else begin
            cur = exp_q.pop_front();
        end
        chk("res", 16'(bus.res), 16'(cur.res));
        chk("res_id", 16'(bus.res_id), 16'(cur.id));
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_valid", 16'(bus.res_valid), 16'h1);
            chk("hold_res", 16'(bus.res), 16'(cur.res));
            chk("hold_id", 16'(bus.res_id), 16'(cur.id));
            chk("hold_gnt", 16'(bus.gnt), 16'h0);
            chk("hold_busy", 16'(bus.busy), 16'h1);
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        chk("done_valid", 16'(bus.res_valid), 16'h0);
        chk("done_busy", 16'(bus.busy), 16'h0);
        chk("done_res", 16'(bus.res), 16'(cur.res));
    endtask

    initial begin
        checks = 0; errors = 0; mptr = 0;
        rst = 1'b1;
        bus.req = '0; bus.order = '0; bus.bnarrow = '0;
        bus.opa = '0; bus.opb = '0; bus.res_ready = 1'b0;
        step();
        do_reset();

        start(3'b001, 3'b000, 3'b000, 12'h00C, 12'h00A); finish(0);
        start(3'b001, 3'b000, 3'b001, 12'h00C, 12'h00E); finish(0);
        start(3'b001, 3'b000, 3'b001, 12'h006, 12'h00E); finish(0);
        start(3'b001, 3'b001, 3'b001, 12'h00C, 12'h004); finish(0);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            start(3'b111, 3'b010, 3'b100, 12'h9E7, 12'hF5B);
            finish(0);
        end

        start(3'b010, 3'b010, 3'b000, 12'h0D0, 12'h0B0); finish(3);

        bus.req = '0; bus.res_ready = 1'b1;
        step(); step();
        bus.res_ready = 1'b0;
        chk("idle_ready_valid", 16'(bus.res_valid), 16'h0);
        chk("idle_ready_busy", 16'(bus.busy), 16'h0);

        do_reset();
        start(3'b100, 3'b000, 3'b000, 12'hF00, 12'hE00);
        step();
        chk("pre_rst_valid", 16'(bus.res_valid), 16'h1);
        bus.req = 3'b110;
        do_reset();
        start(3'b110, 3'b000, 3'b000, 12'h0F0, 12'h030); finish(0);

        do_reset();
        start(3'b001, 3'b000, 3'b000, 12'h00F, 12'h00F);
        bus.req = 3'b011;
        do_reset();
        start(3'b011, 3'b000, 3'b000, 12'h05A, 12'h0FF); finish(1);

        for (int i = 0; i < 12; i++) begin
            start(3'($urandom_range(1, 7)), 3'($urandom), 3'($urandom),
                  12'($urandom), 12'($urandom));
            finish(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
